// File: rtl/op_sequencer.sv
// op_sequencer: single-issue sequencer that reads two operands from an
// external register file, executes one ALU or multiply operation and writes
// the result back. The multiply is an iterative 16-cycle shift-add.
module op_sequencer #(
  parameter int unsigned MUL_EN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  op,
  input  logic [2:0]  src_a,
  input  logic [2:0]  src_b,
  input  logic [2:0]  dst,
  output logic [2:0]  rd_addr_a,
  output logic [2:0]  rd_addr_b,
  input  logic [0:15] rd_data_a,
  input  logic [0:15] rd_data_b,
  output logic        wr,
  output logic [2:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        carry
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    EXEC,
    MUL,
    WRITE
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } opcode_t;

  localparam bit MulOn = (MUL_EN != 0);

  state_t      state;
  state_t      next_state;
  opcode_t     op_q;
  logic [2:0]  dst_q;
  logic [15:0] opa;
  logic [15:0] opb;
  logic [15:0] result;
  logic [15:0] alu_res;
  logic        alu_c;
  logic [31:0] prod;
  logic [31:0] mcand;
  logic [15:0] mplier;
  logic [3:0]  mul_cnt;
  logic [31:0] mul_sum;

  // State register; reset has priority and aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid) next_state = READ;
      READ:    next_state = (op_q == OP_MUL && MulOn) ? MUL : EXEC;
      EXEC:    next_state = WRITE;
      MUL:     if (mul_cnt == 4'd15) next_state = WRITE;
      WRITE:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake, status and write-port outputs. wr/done are also gated by
  // reset so a WRITE cycle with reset low never produces a visible write.
  always_comb begin
    in_ready = (state == IDLE) && reset;
    busy     = (state != IDLE);
    wr       = (state == WRITE) && reset;
    done     = wr;
    wr_addr  = dst_q;
    wr_data  = result;
  end

  // Single-cycle ALU. opb[3:0] is B[12:15] in the register file's MSB-first
  // numbering. MUL reaching EXEC (multiplier disabled) yields 0 with no carry.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    case (op_q)
      OP_ADD:  {alu_c, alu_res} = {1'b0, opa} + {1'b0, opb};
      OP_SUB: begin
        alu_res = opa - opb;
        alu_c   = (opa < opb);
      end
      OP_AND:  alu_res = opa & opb;
      OP_OR:   alu_res = opa | opb;
      OP_XOR:  alu_res = opa ^ opb;
      OP_SHL:  alu_res = opa << opb[3:0];
      OP_SHR:  alu_res = opa >> opb[3:0];
      default: alu_res = '0;
    endcase
  end

  // One shift-add step: add the shifted multiplicand when the current
  // multiplier bit is set.
  always_comb begin
    mul_sum = prod + (mplier[0] ? mcand : 32'h0000_0000);
  end

  // Datapath: latch the request, capture operands, run the multiply and
  // hold result/carry until the next result is produced.
  always_ff @(posedge clk) begin
    if (!reset) begin
      op_q      <= OP_ADD;
      dst_q     <= '0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      opa       <= '0;
      opb       <= '0;
      result    <= '0;
      carry     <= 1'b0;
      prod      <= '0;
      mcand     <= '0;
      mplier    <= '0;
      mul_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q      <= opcode_t'(op);
            dst_q     <= dst;
            rd_addr_a <= src_a;
            rd_addr_b <= src_b;
          end
        end
        READ: begin
          opa     <= rd_data_a;
          opb     <= rd_data_b;
          prod    <= '0;
          mcand   <= {16'h0000, rd_data_a};
          mplier  <= rd_data_b;
          mul_cnt <= '0;
        end
        EXEC: begin
          result <= alu_res;
          carry  <= alu_c;
        end
        MUL: begin
          prod    <= mul_sum;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          mul_cnt <= mul_cnt + 4'd1;
          if (mul_cnt == 4'd15) begin
            result <= mul_sum[15:0];
            carry  <= |mul_sum[31:16];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/op_sequencer.md
OP_SEQUENCER -- requirements
Module: op_sequencer

Interface
REQ-001 Parameter MUL_EN, default 1, SHALL enable the MUL opcode: 1 = enabled, 0 = MUL treated as illegal.
REQ-002 clk  in  1  SHALL be the single clock; all state changes occur on the rising edge.
REQ-003 reset  in  1  SHALL be the reset; it is synchronous and active-low.
REQ-004 in_valid  in  1  SHALL mean an operation is offered.
REQ-005 in_ready  out  1  SHALL mean the block can accept an operation.
REQ-006 op  in  3  SHALL be the opcode.
REQ-007 src_a, src_b, dst  in  3 each  SHALL be the source and destination register indices.
REQ-008 rd_addr_a, rd_addr_b  out  3 each  SHALL be the register-file read addresses.
REQ-009 rd_data_a, rd_data_b  in  16 each  SHALL be the register-file read data; it is combinational from the addresses, with bit 0 as MSB.
REQ-010 wr  out  1, wr_addr  out  3, wr_data  out  16  SHALL be the register-file write strobe, address and data.
REQ-011 busy  out  1, done  out  1, carry  out  1  SHALL be the status outputs.

Function
REQ-012 Acceptance SHALL occur on a rising edge with in_valid=1 and in_ready=1; op, src_a, src_b and dst are latched at that edge and later input changes are ignored.
REQ-013 in_ready SHALL equal (state==IDLE) AND reset; it is combinational and at most one operation is in flight.
REQ-014 The FSM SHALL have states IDLE, READ, EXEC, MUL and WRITE.
  - IDLE->READ on acceptance.
  - READ->EXEC, or READ->MUL when op=111 and MUL_EN=1.
  - EXEC->WRITE.
  - MUL->WRITE after 16 MUL cycles.
  - WRITE->IDLE.
REQ-015 In READ, rd_addr_a/rd_addr_b SHALL drive the latched src_a/src_b, and the operands SHALL be registered at the end of READ.
REQ-016 In all other states rd_addr_a/rd_addr_b SHALL hold their last value; their reset value is 0.
REQ-017 Opcodes SHALL compute the following, with result = low 16 bits:
  - 000: A+B
  - 001: A-B
  - 010: A&B
  - 011: A|B
  - 100: A^B
  - 101: A logical-shift-left by B[12:15]
  - 110: A logical-shift-right by B[12:15]
  - 111: A*B
REQ-018 carry SHALL be set as follows and held until the next result is produced:
  - ADD: carry-out.
  - SUB: borrow, i.e. 1 when A<B unsigned.
  - MUL: 1 when product bits [31:16] are nonzero.
  - All other ops: 0.
REQ-019 MUL SHALL be an iterative shift-add over exactly 16 cycles in state MUL, processing one multiplier bit per cycle.
REQ-020 When MUL_EN=0, op 111 SHALL complete through EXEC with result 0 and carry 0.
REQ-021 In WRITE, the block SHALL assert wr=1, wr_addr=latched dst, wr_data=result and done=1 for exactly one cycle; the write commits at the end of WRITE.
REQ-022 Latency SHALL be 3 cycles from the acceptance edge to the WRITE cycle for non-MUL ops, and 18 cycles for MUL.
REQ-023 wr and done SHALL be 0 in every state other than WRITE.
REQ-024 busy SHALL be 1 in READ, EXEC, MUL and WRITE.
REQ-025 src_a==src_b, and dst equal to either source, SHALL be legal; sources read pre-write values.
REQ-026 A back-to-back op that reads the previous dst SHALL see the new value, because the write commits before the next READ.
REQ-027 in_valid held high during busy SHALL NOT be accepted until IDLE, and is then accepted on the first IDLE edge.

Reset
REQ-028 reset=0 at any rising edge SHALL force IDLE and set these outputs:
  - wr=0, done=0, busy=0, carry=0.
  - wr_addr=0, wr_data=0.
  - rd_addr_a=0, rd_addr_b=0.
REQ-029 Reset asserted mid-operation, including mid-MUL or in WRITE before the edge, SHALL abort the operation with no subsequent write.
REQ-030 Acceptance SHALL be impossible while reset=0, and in_ready SHALL be 1 on the first cycle after reset returns high.

Verification
REQ-031 R1=0x7FFF, R2=0x0001, op=ADD, dst=3 -> wr pulse in cycle 3, wr_addr=3, wr_data=0x8000, carry=0, done=1 for one cycle.
REQ-032 R1=0x0003, R2=0x0005, op=SUB, dst=1 -> wr_data=0xFFFE, carry=1, and a following ADD R1+R1 reads 0xFFFE and writes 0xFFFC with carry=1.
REQ-033 R4=0x0123, R5=0x0010, op=MUL, dst=6 -> wr exactly 18 cycles after acceptance, wr_data=0x1230, carry=0; in_valid held high during MUL is not accepted.
REQ-034 R2=0x8001, R7=0x0011, op=SHL, dst=2 -> wr_data=0x0002, carry=0; with op=SHR -> wr_data=0x4000.
REQ-035 reset=0 pulsed during cycle 10 of a MUL -> no wr pulse ever, busy=0 and in_ready=1 on the first cycle after release, and the next ADD completes normally.
REQ-036 MUL_EN=0, op=MUL -> wr in cycle 3 with wr_data=0x0000 and carry=0.
